audio_mixer_seq: RTL

Time-multiplexed audio mixer that combines NCH signed channel samples into one excess-2^MSBI sample for the sigma-delta DAC. On each sample strobe it snapshots all channels and their volume codes, then accumulates one channel per clock. It saturates the sum, converts it to offset-binary, and presents it on DAC_OUT. DAC_OUT connects directly to the DACin port of the sigma-delta DAC stage.

---
 rtl/audio_mix_pkg.sv | 21 ++
 rtl/audio_mixer_seq_mix_sat.sv | 33 +++
 rtl/audio_mixer_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the time-multiplexed audio mixer.
// Holds the sequencer states, volume codes and accumulator sizing.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  localparam logic [1:0] VOL_MUTE = 2'd0;
  localparam logic [1:0] VOL_Q    = 2'd1;
  localparam logic [1:0] VOL_H    = 2'd2;
  localparam logic [1:0] VOL_F    = 2'd3;

  // Headroom for summing nch full-scale channels
  function automatic int acc_width(input int nch, input int chw);
    return chw + $clog2(nch);
  endfunction

endpackage

// File: rtl/audio_mixer_seq_mix_sat.sv
// Combinational align/clamp/offset-binary stage of the mixer.
// acc (AW signed) -> dac (MSBI+1, excess 2^MSBI), clip when clamped.
module mix_sat #(
  parameter int MSBI = 7,
  parameter int AW   = 10,
  parameter int SH   = 0
) (
  input  logic signed [AW-1:0] acc,
  output logic [MSBI:0]        dac,
  output logic                 clip
);

  localparam int WA = AW + SH;
  localparam logic signed [WA-1:0] HI =
    {{(WA-MSBI){1'b0}}, {MSBI{1'b1}}};
  localparam logic signed [WA-1:0] LO = ~HI;

  logic signed [WA-1:0] al;

  always_comb begin
    al   = WA'(acc) <<< SH;
    clip = 1'b0;
    dac  = {~al[MSBI], al[MSBI-1:0]};
    if (al > HI) begin
      clip = 1'b1;
      dac  = '1;
    end else if (al < LO) begin
      clip = 1'b1;
      dac  = '0;
    end
  end

endmodule

// File: rtl/audio_mixer_seq.sv
// Sequential NCH-channel mixer: snapshots on CE, sums one channel per
// clock, then saturates into an excess-2^MSBI word for the DAC.
module audio_mixer_seq #(
  parameter int MSBI = 7,
  parameter int NCH  = 4,
  parameter int CHW  = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CE,
  input  logic [NCH*CHW-1:0] CH_IN,
  input  logic [NCH*2-1:0] CH_VOL,
  input  logic             CLR_FLAGS,
  output logic [MSBI:0]    DAC_OUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             CLIP,
  output logic             OVERRUN
);

  import audio_mix_pkg::*;

  localparam int AW = acc_width(NCH, CHW);
  localparam int IW = $clog2(NCH);
  localparam int SH = MSBI + 1 - CHW;
  localparam logic [MSBI:0] MID = {1'b1, {MSBI{1'b0}}};

  state_t state, nxt;

  logic [NCH*CHW-1:0]    snap_ch;
  logic [NCH*2-1:0]      snap_vol;
  logic signed [AW-1:0]  acc;
  logic [IW-1:0]         idx;

  logic signed [CHW-1:0] s;
  logic signed [AW-1:0]  se;
  logic signed [AW-1:0]  term;
  logic [1:0]            v;
  logic [MSBI:0]         dac_c;
  logic                  clip_c;

  always_comb begin
    s    = snap_ch[idx*CHW +: CHW];
    v    = snap_vol[idx*2 +: 2];
    se   = AW'(s);
    term = '0;
    unique case (v)
      VOL_MUTE: term = '0;
      VOL_Q:    term = se >>> 2;
      VOL_H:    term = se >>> 1;
      VOL_F:    term = se;
      default:  term = '0;
    endcase
  end

  mix_sat #(
    .MSBI(MSBI),
    .AW  (AW),
    .SH  (SH)
  ) u_sat (
    .acc (acc),
    .dac (dac_c),
    .clip(clip_c)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (CE) nxt = ACC;
      ACC:     if (idx == IW'(NCH-1)) nxt = OUT;
      OUT:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      snap_ch  <= '0;
      snap_vol <= '0;
      acc      <= '0;
      idx      <= '0;
      DAC_OUT  <= MID;
      VALID    <= 1'b0;
      CLIP     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state <= nxt;
      VALID <= 1'b0;
      if (state == IDLE && CE) begin
        snap_ch  <= CH_IN;
        snap_vol <= CH_VOL;
        acc      <= '0;
        idx      <= '0;
      end
      if (state == ACC) begin
        acc <= acc + term;
        idx <= idx + IW'(1);
      end
      if (state == OUT) begin
        DAC_OUT <= dac_c;
        VALID   <= 1'b1;
      end
      // A set in the same cycle as a clear takes priority
      if (state == OUT && clip_c)
        CLIP <= 1'b1;
      else if (CLR_FLAGS)
        CLIP <= 1'b0;
      if (CE && state != IDLE)
        OVERRUN <= 1'b1;
      else if (CLR_FLAGS)
        OVERRUN <= 1'b0;
    end
  end

endmodule
